// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart transmitter between NUM_REQ byte producers.
// Accepts one byte, launches it, then holds the transmitter until tx_done or a watchdog expires.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16384
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       send_request,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       timeout_err
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GRANT_RST = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [GW-1:0] r_last_grant;
    logic [GW-1:0] r_grant_id;
    logic [7:0]    r_tx_data;
    logic [CW-1:0] r_cnt;
    logic [GW-1:0] w_winner;
    logic [GW-1:0] w_idx;
    logic          w_found;
    logic [7:0]    w_win_data;

    // Search for the first valid requester starting just after the last grant.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = GW'((32'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_win_data = req_data[32'(w_winner)*8 +: 8];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the handshake strobes; strobes are held low while reset is high.
    always_comb begin
        w_state_nxt  = r_state;
        req_ready    = '0;
        send_request = 1'b0;
        timeout_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    req_ready[w_winner] = !reset;
                    w_state_nxt         = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (!tx_busy) begin
                    send_request = !reset;
                    w_state_nxt  = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    timeout_err = !reset;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture the accepted byte and its owner; run the saturating watchdog counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= GRANT_RST;
            r_grant_id   <= '0;
            r_tx_data    <= 8'h00;
            r_cnt        <= '0;
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_tx_data    <= w_win_data;
                r_grant_id   <= w_winner;
                r_last_grant <= w_winner;
            end
            if (r_state == S_LAUNCH) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT_DONE && r_cnt != CNT_LAST) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign tx_data  = r_tx_data;
    assign grant_id = r_grant_id;
    assign active   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle vector table, launch scoreboard and a looped-back round-robin run.
module tb_uart_tx_arbiter;

    localparam logic [31:0] DATA    = 32'h77A55A3C;
    localparam logic [31:0] RR_DATA = 32'hD4C3B2A1;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        send_request;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;

    int vecs = 0;
    int miss = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .send_request(send_request), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_id),
        .active(active), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic       busy;
        logic       done;
        logic [3:0] rdy;
        logic       snd;
        logic       act;
        logic [1:0] gid;
        logic [7:0] txd;
        logic       terr;
    } vec_t;

    vec_t       tbl[$];
    logic [9:0] sb[$];
    logic       prev_snd = 1'b0;

    task automatic add(input logic rst, input logic [3:0] v, input logic busy, input logic done,
                       input logic [3:0] rdy, input logic snd, input logic act,
                       input logic [1:0] gid, input logic [7:0] txd, input logic terr);
        vec_t e;
        e.rst = rst; e.v = v; e.busy = busy; e.done = done; e.rdy = rdy;
        e.snd = snd; e.act = act; e.gid = gid; e.txd = txd; e.terr = terr;
        tbl.push_back(e);
    endtask

    // Each launch must carry the owner/byte recorded at accept time and never repeat back-to-back.
    always @(negedge clk) begin
        if (!reset && send_request) begin
            logic [9:0] exp;
            vecs++;
            if (sb.size() == 0) begin
                miss++;
                $display("FAIL launch_unexpected: got grant=%0d data=%h, no accept pending", grant_id, tx_data);
            end else begin
                exp = sb.pop_front();
                if ({grant_id, tx_data, prev_snd} !== {exp, 1'b0}) begin
                    miss++;
                    $display("FAIL launch: got grant=%0d data=%h prev_send=%b, want grant=%0d data=%h prev_send=0",
                             grant_id, tx_data, prev_snd, exp[9:8], exp[7:0]);
                end
            end
        end
        prev_snd <= send_request;
    end

    initial begin
        int          idx;
        int          n;
        int          cyc;
        logic        seen;
        int          ord[5];
        logic [31:0] rrd;

        reset = 1'b1; req_valid = '0; req_data = DATA; tx_busy = 1'b0; tx_done = 1'b0;
        @(posedge clk); #1;

        // Reset, single requester, busy stall, fairness after wrap, watchdog, reset mid-transfer
        add(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 8'h00, 0);
        add(0, 4'b0100, 0, 0, 4'b0100, 0, 0, 0, 8'h00, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 1, 2, 8'hA5, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 2, 8'hA5, 0);
        add(0, 4'b0000, 0, 1, 4'b0000, 0, 1, 2, 8'hA5, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 2, 8'hA5, 0);
        add(0, 4'b0001, 0, 0, 4'b0001, 0, 0, 2, 8'hA5, 0);
        for (int i = 0; i < 5; i++) add(0, 4'b0001, 1, 0, 4'b0000, 0, 1, 0, 8'h3C, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 1, 0, 8'h3C, 0);
        add(0, 4'b0000, 1, 0, 4'b0000, 0, 1, 0, 8'h3C, 0);
        add(0, 4'b0000, 0, 1, 4'b0000, 0, 1, 0, 8'h3C, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 8'h3C, 0);
        add(0, 4'b1001, 0, 0, 4'b1000, 0, 0, 0, 8'h3C, 0);
        add(0, 4'b1001, 0, 0, 4'b0000, 1, 1, 3, 8'h77, 0);
        add(0, 4'b1001, 0, 1, 4'b0000, 0, 1, 3, 8'h77, 0);
        add(0, 4'b1001, 0, 0, 4'b0001, 0, 0, 3, 8'h77, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 1, 0, 8'h3C, 0);
        add(0, 4'b0000, 0, 1, 4'b0000, 0, 1, 0, 8'h3C, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 8'h3C, 0);
        add(0, 4'b0010, 0, 0, 4'b0010, 0, 0, 0, 8'h3C, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 1, 1, 8'h5A, 0);
        for (int i = 0; i < 7; i++) add(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 1, 8'h5A, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 1, 8'h5A, 1);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 1, 8'h5A, 0);
        add(0, 4'b0100, 0, 0, 4'b0100, 0, 0, 1, 8'h5A, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 1, 2, 8'hA5, 0);
        for (int i = 0; i < 7; i++) add(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 2, 8'hA5, 0);
        add(0, 4'b0000, 0, 1, 4'b0000, 0, 1, 2, 8'hA5, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 2, 8'hA5, 0);
        add(0, 4'b1000, 0, 0, 4'b1000, 0, 0, 2, 8'hA5, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 1, 3, 8'h77, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 3, 8'h77, 0);
        add(1, 4'b0000, 0, 0, 4'b0000, 0, 1, 3, 8'h77, 0);
        add(0, 4'b1111, 0, 0, 4'b0001, 0, 0, 0, 8'h00, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 1, 0, 8'h3C, 0);
        add(0, 4'b0000, 0, 1, 4'b0000, 0, 1, 0, 8'h3C, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 8'h3C, 0);

        foreach (tbl[i]) begin
            reset = tbl[i].rst; req_valid = tbl[i].v; tx_busy = tbl[i].busy; tx_done = tbl[i].done;
            req_data = DATA;
            @(negedge clk);
            vecs++;
            if ({req_ready, send_request, active, grant_id, tx_data, timeout_err} !==
                {tbl[i].rdy, tbl[i].snd, tbl[i].act, tbl[i].gid, tbl[i].txd, tbl[i].terr}) begin
                miss++;
                $display("FAIL vec%0d: got rdy=%b snd=%b act=%b gid=%0d txd=%h terr=%b, want rdy=%b snd=%b act=%b gid=%0d txd=%h terr=%b",
                         i, req_ready, send_request, active, grant_id, tx_data, timeout_err,
                         tbl[i].rdy, tbl[i].snd, tbl[i].act, tbl[i].gid, tbl[i].txd, tbl[i].terr);
            end
            if (tbl[i].rdy != 4'b0000) begin
                idx = 0;
                for (int b = 0; b < 4; b++) if (tbl[i].rdy[b]) idx = b;
                sb.push_back({2'(idx), DATA[idx*8 +: 8]});
            end
            @(posedge clk); #1;
        end

        // Round-robin with all requesters held and tx_done looped back one cycle after launch
        reset = 1'b1; req_valid = '0; tx_busy = 1'b0; tx_done = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 4'b1111; rrd = RR_DATA; req_data = rrd;
        ord = '{0, 1, 2, 3, 0};
        n = 0; cyc = 0; seen = 1'b0;
        while (n < 5 && cyc < 100) begin
            tx_done = seen;
            @(negedge clk);
            seen = send_request;
            if (req_ready != 4'b0000) begin
                vecs++;
                if (req_ready !== 4'(1 << ord[n])) begin
                    miss++;
                    $display("FAIL rr_grant%0d: got rdy=%b, want rdy=%b", n, req_ready, 4'(1 << ord[n]));
                end
                sb.push_back({2'(ord[n]), rrd[ord[n]*8 +: 8]});
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (n < 5) begin
            vecs++;
            miss++;
            $display("FAIL rr_timeout: got %0d grants, want 5", n);
        end
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            tx_done = seen;
            @(negedge clk);
            seen = send_request;
            @(posedge clk); #1;
        end

        vecs++;
        if (sb.size() != 0) begin
            miss++;
            $display("FAIL sb_drain: got %0d launches pending, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single transmitter of the `uart` block between `NUM_REQ` independent byte producers. It accepts one byte at a time from the requesters in round-robin order and launches it with a one-cycle `send_request` pulse. It then holds the transmitter until `tx_done` arrives or a watchdog expires. It sits between the client logic and the `uart` `send_request`/`tx_data`/`tx_busy`/`tx_done` ports, and is the only driver of those `uart` inputs.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; must be ≥2.
- `TIMEOUT_CYCLES`, default 16384: maximum number of clocks spent in WAIT_DONE before the transfer is abandoned; must be ≥2.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  bit i means requester i has a byte to send.
- `req_data`  in  NUM_REQ*8  byte of requester i on bits [8i+7:8i].
- `req_ready`  out  NUM_REQ  one-hot accept strobe; the byte transfers on the cycle where valid and ready are both high.
- `send_request`  out  1  one-cycle launch pulse to `uart`.
- `tx_data`  out  8  latched byte to `uart`; stable from accept until the next accept.
- `tx_busy`  in  1  from `uart`; transmitter occupied.
- `tx_done`  in  1  from `uart`; one-cycle end-of-frame pulse.
- `grant_id`  out  $clog2(NUM_REQ)  index of the requester that owns the current or most recent transfer.
- `active`  out  1  high whenever the FSM is not in IDLE.
- `timeout_err`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- The FSM has three states: IDLE, LAUNCH and WAIT_DONE.
- **IDLE**
  - If any `req_valid` is high, the arbiter picks the first set bit, searching from `(last_grant+1) mod NUM_REQ` upward with wrap-around.
  - `req_ready` is driven combinationally: one-hot at the winner, and only in IDLE.
  - On that edge, `tx_data` takes the winner's `req_data`, and both `grant_id` and `last_grant` take the winner's index. The FSM moves to LAUNCH.
  - If no request is present, the FSM stays in IDLE.
- **LAUNCH**
  - `send_request = !tx_busy`, combinational.
  - If `tx_busy` is 0, the pulse goes out this cycle and the FSM moves to WAIT_DONE with the timeout counter cleared.
  - If `tx_busy` is 1, the FSM stays in LAUNCH and `send_request` stays low. The watchdog does not run in this state.
- **WAIT_DONE**
  - The counter increments every cycle.
  - If `tx_done` is 1, the FSM goes to IDLE and no error is raised.
  - Otherwise, if the counter equals `TIMEOUT_CYCLES-1`, `timeout_err` pulses for that cycle and the FSM goes to IDLE.
  - `tx_done` seen in the same cycle as the timeout: `tx_done` wins and no error is raised.
- `tx_done` is ignored in IDLE and LAUNCH.
- `req_valid` or `req_data` changing after the accept has no effect on the transfer in flight.
- A requester may hold `req_valid` continuously. It is served again only after every other valid requester has had one turn.
- Counter width is `$clog2(TIMEOUT_CYCLES)`. The counter saturates and never wraps.

## Timing
- Reset values: state IDLE, `last_grant = NUM_REQ-1` (requester 0 has first priority), `req_ready` 0, `send_request` 0, `tx_data` 8'h00, `grant_id` 0, `active` 0, `timeout_err` 0, counter 0.
- Reset mid-transfer: on the next edge the FSM returns to IDLE and the transfer is abandoned without a `timeout_err`. `send_request` is low during any cycle in which `reset` is high.
- Accept-to-launch latency: accept at edge N, `send_request` high in cycle N+1 if `tx_busy` is 0.
- `active` rises in the cycle after the accept and falls in the cycle after `tx_done` or the timeout.
- Minimum spacing between accepts is 3 cycles: IDLE, then LAUNCH, then WAIT_DONE with `tx_done` immediately.
- At most one `req_ready` bit is high in any cycle, and never while `active` is 1.
- `send_request` is never high for two consecutive cycles.

## Test plan
- **Single requester:** `req_valid[2]=1`, `req_data[2]=8'hA5` → `req_ready` = 4'b0100 for exactly 1 cycle; `tx_data` = 8'hA5 and `send_request` pulses on the next cycle; the bench's `tx_done` returns the FSM to IDLE; `grant_id` = 2.
- **Round-robin:** `req_valid` = 4'b1111 held, with the `uart` model looped back → grant order 0,1,2,3,0; each byte reaches `tx_data` in that order.
- **Fairness after wrap:** `req_valid` = 4'b1001 with `last_grant=0` → next grant is 3, then 0.
- **Busy stall:** `tx_busy` held 1 for 5 cycles in LAUNCH → `send_request` stays low for those cycles, pulses once in the cycle after `tx_busy` falls, and `timeout_err` stays 0.
- **Watchdog:** `TIMEOUT_CYCLES`=8, `tx_done` never asserted → `timeout_err` pulses in the 8th WAIT_DONE cycle and the FSM returns to IDLE. In a second run, `tx_done` arrives on that same 8th cycle → no error.
- **Reset mid-transfer:** `reset` asserted for 1 cycle during WAIT_DONE → all outputs at their reset values the next cycle, no `timeout_err`, and the next grant goes to requester 0.
